// File: rtl/special_reg_write_ctrl_pkg.sv
// Shared definitions for the special-register write controller.
// Contents:
//   DST_*      5-bit destination codes of the seven special registers
//   SR_*       bit positions of each register inside the sr_we strobe vector
//   sr_state_e controller state
package sr_pkg;

    localparam logic [4:0] DST_SHA = 5'b10011;
    localparam logic [4:0] DST_SHB = 5'b10010;
    localparam logic [4:0] DST_PSW = 5'b10111;
    localparam logic [4:0] DST_CWP = 5'b10110;
    localparam logic [4:0] DST_TB  = 5'b10101;
    localparam logic [4:0] DST_SWP = 5'b10100;
    localparam logic [4:0] DST_PC  = 5'b10001;

    localparam int unsigned SR_SHA = 0;
    localparam int unsigned SR_SHB = 1;
    localparam int unsigned SR_PSW = 2;
    localparam int unsigned SR_CWP = 3;
    localparam int unsigned SR_TB  = 4;
    localparam int unsigned SR_SWP = 5;
    localparam int unsigned SR_PC  = 6;
    localparam int unsigned SR_NUM = 7;

    typedef enum logic [1:0] {
        RUN,
        CWP_WAIT,
        TRAP_PSW,
        TRAP_PC
    } sr_state_e;

endpackage

// File: rtl/special_reg_write_ctrl_if.sv
// Bus between the writeback/trap requester and the special-register
// write controller.
// Signals:
//   wb_valid/wb_dst/wb_data  writeback request, accepted when wb_valid & wb_ready
//   wb_ready                 controller can accept a writeback this cycle
//   trap_req/trap_psw/trap_pc trap entry request and its PSW/PC values
//   trap_ack                 one-cycle pulse with the trap PC write
//   sr_we/sr_wdata           one-hot register write strobes and their data
// Modports: master = requester side, slave = controller side.
interface special_reg_write_ctrl_if #(
    parameter int unsigned DW = 32
);
    logic          wb_valid;
    logic [4:0]    wb_dst;
    logic [DW-1:0] wb_data;
    logic          wb_ready;
    logic          trap_req;
    logic [DW-1:0] trap_psw;
    logic [DW-1:0] trap_pc;
    logic          trap_ack;
    logic [6:0]    sr_we;
    logic [DW-1:0] sr_wdata;

    modport master (
        output wb_valid, wb_dst, wb_data, trap_req, trap_psw, trap_pc,
        input  wb_ready, trap_ack, sr_we, sr_wdata
    );

    modport slave (
        input  wb_valid, wb_dst, wb_data, trap_req, trap_psw, trap_pc,
        output wb_ready, trap_ack, sr_we, sr_wdata
    );
endinterface

// File: rtl/special_reg_write_ctrl_dst_decode.sv
// Destination decoder: maps a 5-bit register code to a one-hot strobe
// vector over the seven special registers. Output is zero when valid is
// low or the code names no special register.
// Ports:
//   valid   in   request qualifier
//   dst     in   5-bit destination code
//   onehot  out  7-bit one-hot strobe, bit order SHA..PC
module sr_dst_decode
    import sr_pkg::*;
(
    input  logic              valid,
    input  logic [4:0]        dst,
    output logic [SR_NUM-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (valid) begin
            case (dst)
                DST_SHA: onehot[SR_SHA] = 1'b1;
                DST_SHB: onehot[SR_SHB] = 1'b1;
                DST_PSW: onehot[SR_PSW] = 1'b1;
                DST_CWP: onehot[SR_CWP] = 1'b1;
                DST_TB:  onehot[SR_TB]  = 1'b1;
                DST_SWP: onehot[SR_SWP] = 1'b1;
                DST_PC:  onehot[SR_PC]  = 1'b1;
                default: onehot = '0;
            endcase
        end
    end

endmodule

// File: rtl/special_reg_write_ctrl.sv
// Special-register write controller. Sequences every write to SHA, SHB,
// PSW, CWP, TB, SWP and PC: accepts writeback requests, runs two-cycle
// trap entry (PSW then PC) with priority over writeback, and stalls
// writeback for CWP_SETTLE cycles after a CWP write.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high
//   bus    slave side of special_reg_write_ctrl_if (writeback, trap, strobes)
// Parameters:
//   DW          data width (must match the interface)
//   CWP_SETTLE  cycles wb_ready stays low after a CWP strobe (>=1)
module special_reg_write_ctrl
    import sr_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned CWP_SETTLE = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    special_reg_write_ctrl_if.slave        bus
);

    localparam int unsigned CW = (CWP_SETTLE < 2) ? 1 : $clog2(CWP_SETTLE + 1);

    sr_state_e         state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [SR_NUM-1:0] we_q, we_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic [SR_NUM-1:0] dec;

    sr_dst_decode u_dec (
        .valid  (bus.wb_valid),
        .dst    (bus.wb_dst),
        .onehot (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
        end
    end

    // Strobes default to zero every cycle, so each write is a single-cycle
    // pulse; write data is only reloaded when a strobe is issued.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_d    = '0;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        case (state)
            RUN: begin
                if (bus.trap_req) begin
                    we_d[SR_PSW] = 1'b1;
                    wdata_d      = bus.trap_psw;
                    state_d      = TRAP_PSW;
                end else if (dec != '0) begin
                    we_d    = dec;
                    wdata_d = bus.wb_data;
                    if (dec[SR_CWP]) begin
                        state_d = CWP_WAIT;
                        cnt_d   = CW'(CWP_SETTLE);
                    end
                end
            end
            CWP_WAIT: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = RUN;
                end
            end
            TRAP_PSW: begin
                we_d[SR_PC] = 1'b1;
                wdata_d     = bus.trap_pc;
                ack_d       = 1'b1;
                state_d     = TRAP_PC;
            end
            TRAP_PC: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.wb_ready = !reset && (state == RUN) && !bus.trap_req;
    assign bus.sr_we    = we_q;
    assign bus.sr_wdata = wdata_q;
    assign bus.trap_ack = ack_q;

endmodule

// File: tb/tb_special_reg_write_ctrl.sv
// Bench for special_reg_write_ctrl: directed vector table, hand-written
// CWP/trap/reset sequences, then random traffic against a timeline model.
module tb_special_reg_write_ctrl;

    localparam int unsigned DW     = 32;
    localparam int unsigned SETTLE = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    special_reg_write_ctrl_if #(.DW(DW)) bus ();

    special_reg_write_ctrl #(
        .DW         (DW),
        .CWP_SETTLE (SETTLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Destination code of each strobe bit, bit 0 (SHA) .. bit 6 (PC).
    logic [4:0] code_of_bit [7] = '{5'b10011, 5'b10010, 5'b10111, 5'b10110,
                                   5'b10101, 5'b10100, 5'b10001};

    typedef struct {
        logic        valid;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [6:0]  exp_we;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ref_strobe(input logic v, input logic [4:0] d);
        logic [6:0] r;
        r = '0;
        if (v) begin
            for (int i = 0; i < 7; i++) begin
                if (code_of_bit[i] == d) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Timeline model state
    logic [6:0]  m_we   [int];
    logic [31:0] m_data [int];
    bit          m_ack  [int];

    initial begin
        int          c;
        int          ready_at;
        bit          rst_prev;
        bit          cur_ack;
        logic [6:0]  exp_we;
        logic [31:0] last;
        logic [6:0]  s;

        checks = 0;
        errors = 0;

        tbl[0] = '{1'b1, 5'b10010, 32'h1111_0002, 7'h02};
        tbl[1] = '{1'b1, 5'b10101, 32'h2222_0010, 7'h10};
        tbl[2] = '{1'b1, 5'b10001, 32'h3333_0040, 7'h40};
        tbl[3] = '{1'b1, 5'b00000, 32'hDEAD_0000, 7'h00};
        tbl[4] = '{1'b1, 5'b10111, 32'h4444_0004, 7'h04};
        tbl[5] = '{1'b1, 5'b10100, 32'h5555_0020, 7'h20};
        tbl[6] = '{1'b1, 5'b10011, 32'h6666_0001, 7'h01};
        tbl[7] = '{1'b1, 5'b11111, 32'hBEEF_0000, 7'h00};
        tbl[8] = '{1'b1, 5'b10000, 32'hCAFE_0000, 7'h00};
        tbl[9] = '{1'b0, 5'b10011, 32'hF00D_0000, 7'h00};

        reset        = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_dst   = '0;
        bus.wb_data  = '0;
        bus.trap_req = 1'b0;
        bus.trap_psw = '0;
        bus.trap_pc  = '0;
        step();
        step();
        chk("reset_we", bus.sr_we, 0);
        chk("reset_wdata", bus.sr_wdata, 0);
        chk("reset_ack", bus.trap_ack, 0);
        chk("reset_ready", bus.wb_ready, 0);
        reset = 1'b0;
        #1;
        chk("run_ready", bus.wb_ready, 1);

        // Single SHA write
        bus.wb_valid = 1'b1; bus.wb_dst = 5'b10011; bus.wb_data = 32'hA5A5_A5A5;
        step();
        bus.wb_valid = 1'b0;
        chk("sha_we", bus.sr_we, 7'h01);
        chk("sha_wdata", bus.sr_wdata, 32'hA5A5_A5A5);
        step();
        chk("sha_we_off", bus.sr_we, 0);
        chk("sha_wdata_hold", bus.sr_wdata, 32'hA5A5_A5A5);

        // Back-to-back table
        for (int i = 0; i < 10; i++) begin
            bus.wb_valid = tbl[i].valid;
            bus.wb_dst   = tbl[i].dst;
            bus.wb_data  = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_ready", i), bus.wb_ready, 1);
            step();
            chk($sformatf("tbl%0d_we", i), bus.sr_we, tbl[i].exp_we);
            if (tbl[i].exp_we != 0) chk($sformatf("tbl%0d_wdata", i), bus.sr_wdata, tbl[i].data);
        end
        bus.wb_valid = 1'b0;
        step();
        chk("tbl_end_we", bus.sr_we, 0);

        // CWP settle with a held request
        bus.wb_valid = 1'b1; bus.wb_dst = 5'b10110; bus.wb_data = 32'h0000_000C;
        step();
        bus.wb_dst = 5'b10011; bus.wb_data = 32'h0000_000D;
        #1;
        chk("cwp_we", bus.sr_we, 7'h08);
        chk("cwp_wdata", bus.sr_wdata, 32'h0000_000C);
        chk("cwp_ready1", bus.wb_ready, 0);
        step();
        chk("cwp_we_off", bus.sr_we, 0);
        chk("cwp_ready2", bus.wb_ready, 0);
        step();
        chk("cwp_ready3", bus.wb_ready, 0);
        step();
        chk("cwp_ready4", bus.wb_ready, 1);
        step();
        bus.wb_valid = 1'b0;
        chk("cwp_held_we", bus.sr_we, 7'h01);
        chk("cwp_held_wdata", bus.sr_wdata, 32'h0000_000D);

        // Trap wins over simultaneous writeback
        bus.trap_req = 1'b1; bus.trap_psw = 32'h11; bus.trap_pc = 32'h80;
        bus.wb_valid = 1'b1; bus.wb_dst = 5'b10011; bus.wb_data = 32'h0000_000E;
        #1;
        chk("trap_ready0", bus.wb_ready, 0);
        step();
        chk("trap_psw_we", bus.sr_we, 7'h04);
        chk("trap_psw_wdata", bus.sr_wdata, 32'h11);
        chk("trap_psw_ack", bus.trap_ack, 0);
        step();
        chk("trap_pc_we", bus.sr_we, 7'h40);
        chk("trap_pc_wdata", bus.sr_wdata, 32'h80);
        chk("trap_pc_ack", bus.trap_ack, 1);
        bus.trap_req = 1'b0;
        #1;
        chk("trap_pc_ready", bus.wb_ready, 0);
        step();
        chk("trap_end_we", bus.sr_we, 0);
        chk("trap_end_ack", bus.trap_ack, 0);
        chk("trap_end_ready", bus.wb_ready, 1);
        step();
        bus.wb_valid = 1'b0;
        chk("trap_wb_we", bus.sr_we, 7'h01);
        chk("trap_wb_wdata", bus.sr_wdata, 32'h0000_000E);

        // Trap raised during CWP wait
        bus.wb_valid = 1'b1; bus.wb_dst = 5'b10110; bus.wb_data = 32'h5;
        step();
        bus.wb_valid = 1'b0;
        bus.trap_req = 1'b1; bus.trap_psw = 32'h22; bus.trap_pc = 32'h90;
        chk("cwpt_we", bus.sr_we, 7'h08);
        step();
        chk("cwpt_w2", bus.sr_we, 0);
        step();
        chk("cwpt_w3", bus.sr_we, 0);
        chk("cwpt_ready3", bus.wb_ready, 0);
        step();
        chk("cwpt_run_we", bus.sr_we, 0);
        chk("cwpt_run_ready", bus.wb_ready, 0);
        step();
        chk("cwpt_psw_we", bus.sr_we, 7'h04);
        chk("cwpt_psw_wdata", bus.sr_wdata, 32'h22);
        step();
        chk("cwpt_pc_we", bus.sr_we, 7'h40);
        chk("cwpt_pc_wdata", bus.sr_wdata, 32'h90);
        chk("cwpt_ack", bus.trap_ack, 1);
        bus.trap_req = 1'b0;
        step();
        chk("cwpt_end_we", bus.sr_we, 0);
        chk("cwpt_end_ready", bus.wb_ready, 1);

        // Reset during TRAP_PSW
        bus.trap_req = 1'b1; bus.trap_psw = 32'h33; bus.trap_pc = 32'hA0;
        step();
        chk("rtrap_psw_we", bus.sr_we, 7'h04);
        reset = 1'b1;
        step();
        chk("rtrap_we", bus.sr_we, 0);
        chk("rtrap_ack", bus.trap_ack, 0);
        chk("rtrap_ready", bus.wb_ready, 0);
        chk("rtrap_wdata", bus.sr_wdata, 0);
        bus.trap_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("rtrap_ready_after", bus.wb_ready, 1);
        step();
        chk("rtrap_we_after", bus.sr_we, 0);

        // Random traffic against timeline model
        reset = 1'b1;
        step();
        reset = 1'b0;
        c = 0; ready_at = 0; last = '0; cur_ack = 0;
        for (int k = 0; k < 3000; k++) begin
            if (cur_ack) begin
                bus.trap_req = 1'b0;
            end else if (!bus.trap_req && $urandom_range(0, 11) == 0) begin
                bus.trap_req = 1'b1;
                bus.trap_psw = $urandom;
                bus.trap_pc  = $urandom;
            end
            reset        = ($urandom_range(0, 63) == 0);
            bus.wb_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) bus.wb_dst = code_of_bit[$urandom_range(0, 6)];
            else bus.wb_dst = 5'($urandom_range(0, 31));
            bus.wb_data = $urandom;
            #1;
            chk("rnd_ready", bus.wb_ready, (!reset && c >= ready_at && !bus.trap_req) ? 1 : 0);

            rst_prev = reset;
            if (reset) begin
                m_we.delete(); m_data.delete(); m_ack.delete();
                ready_at = c + 1;
            end else if (c >= ready_at) begin
                if (bus.trap_req) begin
                    m_we[c+1] = 7'h04; m_data[c+1] = bus.trap_psw; m_ack[c+1] = 0;
                    m_we[c+2] = 7'h40; m_data[c+2] = bus.trap_pc;  m_ack[c+2] = 1;
                    ready_at = c + 3;
                end else begin
                    s = ref_strobe(bus.wb_valid, bus.wb_dst);
                    if (s != 0) begin
                        m_we[c+1] = s; m_data[c+1] = bus.wb_data; m_ack[c+1] = 0;
                        if (s == 7'h08) ready_at = c + 1 + SETTLE;
                    end
                end
            end

            step();
            c++;
            exp_we = '0; cur_ack = 0;
            if (rst_prev) begin
                last = '0;
            end else if (m_we.exists(c)) begin
                exp_we = m_we[c]; last = m_data[c]; cur_ack = m_ack[c];
                m_we.delete(c); m_data.delete(c); m_ack.delete(c);
            end
            chk("rnd_we", bus.sr_we, exp_we);
            chk("rnd_ack", bus.trap_ack, cur_ack);
            chk("rnd_wdata", bus.sr_wdata, last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
